// File: rtl/adder_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_display_pkg
//  Purpose  : Shared FSM state type and seven-segment constants for the
//             adder display sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package adder_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_CONV = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Active-low segments, bit6 = a .. bit0 = g
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [0:9][6:0] SEG_PATTERN = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
        7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
    };

endpackage
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_decoder
//  Purpose  : BCD digit to active-low seven-segment pattern; 10..15 blank.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    import adder_display_pkg::*;

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_PATTERN[digit];
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adder_display_sequencer
//  Purpose  : Adds two 4-bit operands, converts the sum to BCD and scans it
//             onto a two-digit multiplexed seven-segment display.
//             Option: DISPLAY_BLANK_LEADING_ZERO_EN blanks a zero tens digit.
//  Revision : 1.0  initial release
// ============================================================================
module adder_display_sequencer #(
    parameter int REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic [4:0] sum_out,
    output logic [3:0] tens_out,
    output logic [3:0] ones_out,
    output logic       result_valid,
    output logic [6:0] seg,
    output logic [1:0] an
);
    import adder_display_pkg::*;

    state_t      r_state;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [15:0] r_refresh_cnt;
    logic        r_digit_sel;
    logic        r_shown;

    logic        w_handshake;
    logic [3:0]  w_conv_tens;
    logic [3:0]  w_conv_ones;
    logic        w_conv_done;
    logic        w_cnt_wrap;
    logic        w_sel_nxt;
    logic        w_shown_nxt;
    logic [3:0]  w_tens_nxt;
    logic [3:0]  w_ones_nxt;
    logic [3:0]  w_digit_nxt;
    logic [6:0]  w_seg_dec;
    logic [6:0]  w_seg_nxt;
    logic [1:0]  w_an_nxt;

    assign w_handshake = in_valid && in_ready;

    // Ones digit is computed modulo 16 on the low nibble: the true remainder
    // is below 10, so subtracting 30/20/10 mod 16 (14/4/10) is exact.
    always_comb begin
        w_conv_tens = 4'd0;
        w_conv_ones = sum_out[3:0];
        if (sum_out >= 5'd30) begin
            w_conv_tens = 4'd3;
            w_conv_ones = sum_out[3:0] - 4'd14;
        end else if (sum_out >= 5'd20) begin
            w_conv_tens = 4'd2;
            w_conv_ones = sum_out[3:0] - 4'd4;
        end else if (sum_out >= 5'd10) begin
            w_conv_tens = 4'd1;
            w_conv_ones = sum_out[3:0] - 4'd10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            in_ready     <= 1'b0;
            r_a          <= 4'd0;
            r_b          <= 4'd0;
            sum_out      <= 5'd0;
            tens_out     <= 4'd0;
            ones_out     <= 4'd0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_SHOW: begin
                    if (w_handshake) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_state  <= S_ADD;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_ADD: begin
                    sum_out  <= {1'b0, r_a} + {1'b0, r_b};
                    r_state  <= S_CONV;
                    in_ready <= 1'b0;
                end
                S_CONV: begin
                    tens_out     <= w_conv_tens;
                    ones_out     <= w_conv_ones;
                    result_valid <= 1'b1;
                    r_state      <= S_SHOW;
                    in_ready     <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Display outputs are registered from next-cycle values so seg/an change
    // on exactly the edge where digit_sel or the shown digits change.
    assign w_cnt_wrap  = (r_refresh_cnt == 16'(REFRESH_DIV - 1));
    assign w_sel_nxt   = r_digit_sel ^ w_cnt_wrap;
    assign w_conv_done = (r_state == S_CONV);
    assign w_shown_nxt = r_shown | w_conv_done;
    assign w_tens_nxt  = w_conv_done ? w_conv_tens : tens_out;
    assign w_ones_nxt  = w_conv_done ? w_conv_ones : ones_out;
    assign w_digit_nxt = w_sel_nxt ? w_tens_nxt : w_ones_nxt;

    seven_seg_decoder u_dec (
        .digit (w_digit_nxt),
        .seg   (w_seg_dec)
    );

    always_comb begin
        w_an_nxt  = 2'b11;
        w_seg_nxt = SEG_BLANK;
        if (w_shown_nxt) begin
            if (!w_sel_nxt) begin
                w_an_nxt  = 2'b10;
                w_seg_nxt = w_seg_dec;
            end else begin
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
                if (w_tens_nxt != 4'd0) begin
                    w_an_nxt  = 2'b01;
                    w_seg_nxt = w_seg_dec;
                end
`else
                w_an_nxt  = 2'b01;
                w_seg_nxt = w_seg_dec;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= 16'd0;
            r_digit_sel   <= 1'b0;
            r_shown       <= 1'b0;
            an            <= 2'b11;
            seg           <= SEG_BLANK;
        end else begin
            r_refresh_cnt <= w_cnt_wrap ? 16'd0 : r_refresh_cnt + 16'd1;
            r_digit_sel   <= w_sel_nxt;
            r_shown       <= w_shown_nxt;
            an            <= w_an_nxt;
            seg           <= w_seg_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_display_sequencer
//  Purpose  : Self-checking bench: directed vector table, hand sequences for
//             streaming/reset/refresh corners, and randomized traffic against
//             a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_display_sequencer;

    localparam int TB_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a_in = 4'd0;
    logic [3:0] b_in = 4'd0;
    logic       in_ready;
    logic [4:0] sum_out;
    logic [3:0] tens_out;
    logic [3:0] ones_out;
    logic       result_valid;
    logic [6:0] seg;
    logic [1:0] an;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    adder_display_sequencer #(.REFRESH_DIV(TB_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .sum_out      (sum_out),
        .tens_out     (tens_out),
        .ones_out     (ones_out),
        .result_valid (result_valid),
        .seg          (seg),
        .an           (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Active-low a..g patterns for a standard seven-segment digit
    function automatic int tb_seg(input int d);
        case (d)
            0: return 'h01;  1: return 'h4F;  2: return 'h12;  3: return 'h06;
            4: return 'h4C;  5: return 'h24;  6: return 'h20;  7: return 'h0F;
            8: return 'h00;  9: return 'h04;
            default: return 'h7F;
        endcase
    endfunction

    // Reference model: a transaction takes two clocks after acceptance; the
    // scan slot is purely a function of clocks elapsed since reset.
    int m_k = 0, m_busy = 0, m_ready = 0, m_rv = 0, m_shown = 0;
    int m_sum = 0, m_tens = 0, m_ones = 0, m_pa = 0, m_pb = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0; m_busy <= 0; m_ready <= 0; m_rv <= 0; m_shown <= 0;
            m_sum <= 0; m_tens <= 0; m_ones <= 0;
        end else begin
            m_k  <= m_k + 1;
            m_rv <= 0;
            if (m_busy == 2) begin
                m_busy <= 1;
                m_sum  <= m_pa + m_pb;
            end else if (m_busy == 1) begin
                m_busy  <= 0;
                m_tens  <= m_sum / 10;
                m_ones  <= m_sum % 10;
                m_rv    <= 1;
                m_shown <= 1;
                m_ready <= 1;
            end else if (m_ready == 1 && in_valid) begin
                m_pa    <= int'(a_in);
                m_pb    <= int'(b_in);
                m_busy  <= 2;
                m_ready <= 0;
            end else begin
                m_ready <= 1;
            end
        end
    end

    function automatic int exp_an();
        if (m_shown == 0) return 3;
        if (((m_k / TB_DIV) % 2) == 0) return 2;
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
        if (m_tens == 0) return 3;
`endif
        return 1;
    endfunction

    function automatic int exp_seg();
        if (m_shown == 0) return 'h7F;
        if (((m_k / TB_DIV) % 2) == 0) return tb_seg(m_ones);
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
        if (m_tens == 0) return 'h7F;
`endif
        return tb_seg(m_tens);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",     int'(in_ready),     m_ready);
            check("result_valid", int'(result_valid), m_rv);
            check("sum_out",      int'(sum_out),      m_sum);
            check("tens_out",     int'(tens_out),     m_tens);
            check("ones_out",     int'(ones_out),     m_ones);
            check("an",           int'(an),           exp_an());
            check("seg",          int'(seg),          exp_seg());
        end
    end

    typedef struct {
        int a;
        int b;
        int sum;
        int tens;
        int ones;
    } vec_t;

    vec_t vecs[5];

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk); #1;
        in_valid = 1'b1; a_in = 4'(v.a); b_in = 4'(v.b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (result_valid) lat = i;
        end
        check("vec_latency", lat, 2);
        check("vec_sum",  int'(sum_out),  v.sum);
        check("vec_tens", int'(tens_out), v.tens);
        check("vec_ones", int'(ones_out), v.ones);
    endtask

    initial begin
        int cnt;
        int prev_an;
        vecs[0] = '{3, 5, 8, 0, 8};
        vecs[1] = '{15, 15, 30, 3, 0};
        vecs[2] = '{7, 9, 16, 1, 6};
        vecs[3] = '{8, 7, 15, 1, 5};
        vecs[4] = '{11, 11, 22, 2, 2};

        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        idle(3);
        rst_n = 1'b1;

        // No traffic after reset: display must stay blank
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an != 2'b11 || seg != 7'h7F || !in_ready) cnt++;
        end
        check("idle_blank_cycles", cnt, 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            idle(3 * TB_DIV);
        end

        // Result 22 is still displayed: both slots decode 2, scan alternates
        cnt = 0;
        prev_an = -1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("scan_seg", int'(seg), tb_seg(2));
            check("scan_both_low", int'(an == 2'b00), 0);
            if (prev_an >= 0 && int'(an) != prev_an) cnt++;
            prev_an = int'(an);
        end
        check("scan_toggles", cnt, 4);

        // Continuous in_valid with changing operands
        cnt = 0;
        @(negedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (result_valid) cnt++;
            #1;
            a_in = 4'($urandom_range(15));
            b_in = 4'($urandom_range(15));
        end
        in_valid = 1'b0;
        check("stream_results", cnt, 10);
        idle(4);

        // Reset pulse during CONV of 12+10
        @(negedge clk); #1;
        in_valid = 1'b1; a_in = 4'd12; b_in = 4'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_an",  int'(an),  3);
        check("rst_seg", int'(seg), 'h7F);
        check("rst_sum", int'(sum_out), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid || an != 2'b11) cnt++;
        end
        check("abort_no_result", cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            in_valid = ($urandom_range(2) != 0);
            a_in = 4'($urandom_range(15));
            b_in = 4'($urandom_range(15));
        end
        idle(5);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
